// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t : sequencer state (BOOT, RUN, HALT, FAULT)
//   HALT_INSN     : CBZ XZR,#0 self-loop, treated as the program-end marker
//   PC_INC        : byte distance between consecutive instruction words
//   PC_W/INSTR_W/IMEM_AW : default widths shared by the interface and top
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMEM_AW = 7;

  localparam logic [31:0] HALT_INSN = 32'hb400001f;
  localparam logic [63:0] PC_INC    = 64'd4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundle of the fetch sequencer's imem, control and IF/ID signals.
//   imem_addr/imem_q             : word address out, instruction word back
//   stall                        : hazard unit holds IF/ID
//   branch_taken/branch_target   : MEM-stage redirect
//   if_pc/if_instr/if_valid      : IF/ID boundary registers
//   halted/fault/fetch_count     : status outputs
// Modports: master = fetch_ctrl side, slave = surrounding pipeline/imem side.
interface fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int unsigned N  = PC_W,
  parameter int unsigned IW = INSTR_W,
  parameter int unsigned AW = IMEM_AW
);

  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_q;
  logic          stall;
  logic          branch_taken;
  logic [N-1:0]  branch_target;
  logic [N-1:0]  if_pc;
  logic [IW-1:0] if_instr;
  logic          if_valid;
  logic          halted;
  logic          fault;
  logic [31:0]   fetch_count;

  modport master (
    output imem_addr,
    input  imem_q,
    input  stall,
    input  branch_taken,
    input  branch_target,
    output if_pc,
    output if_instr,
    output if_valid,
    output halted,
    output fault,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_q,
    output stall,
    output branch_taken,
    output branch_target,
    input  if_pc,
    input  if_instr,
    input  if_valid,
    input  halted,
    input  fault,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, addresses the
// combinational instruction memory, registers the fetched word into IF/ID,
// and handles stall, MEM-stage redirect, halt and misaligned-redirect fault.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : fetch_ctrl_if.master (imem address/data, stall, redirect,
//           IF/ID outputs, halted, fault, fetch_count)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned    N        = PC_W,
  parameter int unsigned    IW       = INSTR_W,
  parameter int unsigned    AW       = IMEM_AW,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);

  fetch_state_t state;
  logic [N-1:0] pc;

  // Bits above AW+1 are ignored, so fetch wraps at 4*2^AW bytes.
  assign bus.imem_addr = pc[AW+1:2];

  // Sequencer FSM with the PC, IF/ID registers and delivery counter.
  // BOOT spends one edge without capturing so reset release skew cannot
  // produce a half-valid first fetch. In RUN a redirect outranks stall,
  // and both outrank halt detection. HALT and FAULT are left only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= BOOT;
      pc              <= RESET_PC;
      bus.if_pc       <= '0;
      bus.if_instr    <= '0;
      bus.if_valid    <= 1'b0;
      bus.halted      <= 1'b0;
      bus.fault       <= 1'b0;
      bus.fetch_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (bus.branch_taken) begin
            // Squash the wrong-path word already sitting in IF/ID.
            bus.if_valid <= 1'b0;
            if (bus.branch_target[1:0] != 2'b00) begin
              state     <= FAULT;
              bus.fault <= 1'b1;
            end else begin
              pc <= bus.branch_target;
            end
          end else if (!bus.stall) begin
            bus.if_instr    <= bus.imem_q;
            bus.if_pc       <= pc;
            bus.if_valid    <= 1'b1;
            pc              <= pc + N'(PC_INC);
            bus.fetch_count <= bus.fetch_count + 32'd1;
            if (bus.imem_q == IW'(HALT_INSN)) begin
              state      <= HALT;
              bus.halted <= 1'b1;
            end
          end
        end
        HALT: begin
          // The halt word stays visible until decode accepts it.
          if (!bus.stall) begin
            bus.if_valid <= 1'b0;
          end
        end
        FAULT: begin
          bus.if_valid <= 1'b0;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl. Models a
// 128-word combinational instruction memory with word i = 32'hA000_0000+i,
// except word 0 = 32'hf8000001 and word 85 (byte 0x154) = HALT_INSN.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic clk;
  logic reset;
  logic [31:0] mem [128];

  int checks;
  int errors;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Combinational instruction memory, same-cycle read.
  assign bus.imem_q = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0h expected 0", bus.if_valid); end
    checks++; if (bus.if_pc !== 64'h0) begin errors++; $display("[TB] FAIL rst_pc: got %0h expected 0", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr: got %0h expected 0", bus.if_instr); end
    checks++; if (bus.halted !== 1'b0 || bus.fault !== 1'b0) begin errors++; $display("[TB] FAIL rst_status: got halted=%0h fault=%0h expected 0/0", bus.halted, bus.fault); end
    checks++; if (bus.fetch_count !== 32'h0) begin errors++; $display("[TB] FAIL rst_count: got %0h expected 0", bus.fetch_count); end
    checks++; if (bus.imem_addr !== 7'd0) begin errors++; $display("[TB] FAIL rst_addr: got %0h expected 0", bus.imem_addr); end
    reset = 1'b1;
    step();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL boot_valid: got %0h expected 0", bus.if_valid); end
    step();
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %0h expected 1", bus.if_valid); end
    checks++; if (bus.if_pc !== 64'h0) begin errors++; $display("[TB] FAIL first_pc: got %0h expected 0", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'hf8000001) begin errors++; $display("[TB] FAIL first_instr: got %0h expected f8000001", bus.if_instr); end
    checks++; if (bus.fetch_count !== 32'd1) begin errors++; $display("[TB] FAIL first_count: got %0d expected 1", bus.fetch_count); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++; if (bus.if_pc !== 64'(4 * i)) begin errors++; $display("[TB] FAIL seq_pc%0d: got %0h expected %0h", i, bus.if_pc, 4 * i); end
      checks++; if (bus.if_instr !== (32'ha0000000 + 32'(i))) begin errors++; $display("[TB] FAIL seq_instr%0d: got %0h expected %0h", i, bus.if_instr, 32'ha0000000 + 32'(i)); end
      checks++; if (bus.imem_addr !== 7'(i + 1)) begin errors++; $display("[TB] FAIL seq_addr%0d: got %0d expected %0d", i, bus.imem_addr, i + 1); end
      checks++; if (bus.fetch_count !== 32'(i + 1)) begin errors++; $display("[TB] FAIL seq_count%0d: got %0d expected %0d", i, bus.fetch_count, i + 1); end
    end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.if_pc !== 64'h8) begin errors++; $display("[TB] FAIL stall_pc%0d: got %0h expected 8", i, bus.if_pc); end
      checks++; if (bus.if_instr !== 32'ha0000002) begin errors++; $display("[TB] FAIL stall_instr%0d: got %0h expected a0000002", i, bus.if_instr); end
      checks++; if (bus.fetch_count !== 32'd3) begin errors++; $display("[TB] FAIL stall_count%0d: got %0d expected 3", i, bus.fetch_count); end
      checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid%0d: got %0h expected 1", i, bus.if_valid); end
    end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.if_pc !== 64'hc) begin errors++; $display("[TB] FAIL resume_pc: got %0h expected c", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'ha0000003) begin errors++; $display("[TB] FAIL resume_instr: got %0h expected a0000003", bus.if_instr); end
    checks++; if (bus.fetch_count !== 32'd4) begin errors++; $display("[TB] FAIL resume_count: got %0d expected 4", bus.fetch_count); end
    step();
    checks++; if (bus.if_pc !== 64'h10) begin errors++; $display("[TB] FAIL seq_pc16: got %0h expected 10", bus.if_pc); end
    checks++; if (bus.fetch_count !== 32'd5) begin errors++; $display("[TB] FAIL seq_count5: got %0d expected 5", bus.fetch_count); end
    checks++; if (bus.imem_addr !== 7'd5) begin errors++; $display("[TB] FAIL seq_addr5: got %0d expected 5", bus.imem_addr); end
  endtask

  task automatic test_redirect();
    bus.branch_taken  = 1'b1;
    bus.stall         = 1'b1;
    bus.branch_target = 64'h40;
    step();
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b0;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_bubble: got %0h expected 0", bus.if_valid); end
    checks++; if (bus.imem_addr !== 7'd16) begin errors++; $display("[TB] FAIL redir_addr: got %0d expected 16", bus.imem_addr); end
    checks++; if (bus.fetch_count !== 32'd5) begin errors++; $display("[TB] FAIL redir_count_hold: got %0d expected 5", bus.fetch_count); end
    step();
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_valid: got %0h expected 1", bus.if_valid); end
    checks++; if (bus.if_pc !== 64'h40) begin errors++; $display("[TB] FAIL redir_pc: got %0h expected 40", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'ha0000010) begin errors++; $display("[TB] FAIL redir_instr: got %0h expected a0000010", bus.if_instr); end
    checks++; if (bus.fetch_count !== 32'd6) begin errors++; $display("[TB] FAIL redir_count: got %0d expected 6", bus.fetch_count); end
  endtask

  task automatic test_async_reset();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'h20;
    step();
    bus.branch_taken = 1'b0;
    step();
    checks++; if (bus.if_pc !== 64'h20 || bus.fetch_count !== 32'd7) begin errors++; $display("[TB] FAIL pre_areset: got pc=%0h count=%0d expected 20/7", bus.if_pc, bus.fetch_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %0h expected 0", bus.if_valid); end
    checks++; if (bus.if_pc !== 64'h0) begin errors++; $display("[TB] FAIL areset_pc: got %0h expected 0", bus.if_pc); end
    checks++; if (bus.fetch_count !== 32'h0) begin errors++; $display("[TB] FAIL areset_count: got %0d expected 0", bus.fetch_count); end
    checks++; if (bus.imem_addr !== 7'd0) begin errors++; $display("[TB] FAIL areset_addr: got %0d expected 0", bus.imem_addr); end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_boot: got %0h expected 0", bus.if_valid); end
    step();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h0) begin errors++; $display("[TB] FAIL restart: got valid=%0h pc=%0h expected 1/0", bus.if_valid, bus.if_pc); end
    checks++; if (bus.fetch_count !== 32'd1) begin errors++; $display("[TB] FAIL restart_count: got %0d expected 1", bus.fetch_count); end
  endtask

  task automatic test_fault();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'h42;
    step();
    bus.branch_taken = 1'b0;
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_set: got %0h expected 1", bus.fault); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL fault_valid: got %0h expected 0", bus.if_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.fault !== 1'b1 || bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL fault_stick%0d: got fault=%0h valid=%0h expected 1/0", i, bus.fault, bus.if_valid); end
      checks++; if (bus.fetch_count !== 32'd1 || bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL fault_count%0d: got count=%0d halted=%0h expected 1/0", i, bus.fetch_count, bus.halted); end
    end
  endtask

  task automatic test_halt();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    checks++; if (bus.fault !== 1'b0 || bus.if_pc !== 64'h0) begin errors++; $display("[TB] FAIL fault_clear: got fault=%0h pc=%0h expected 0/0", bus.fault, bus.if_pc); end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'h150;
    step();
    bus.branch_taken = 1'b0;
    step();
    checks++; if (bus.if_pc !== 64'h150 || bus.if_instr !== 32'ha0000054) begin errors++; $display("[TB] FAIL pre_halt: got pc=%0h instr=%0h expected 150/a0000054", bus.if_pc, bus.if_instr); end
    step();
    checks++; if (bus.if_pc !== 64'h154) begin errors++; $display("[TB] FAIL halt_pc: got %0h expected 154", bus.if_pc); end
    checks++; if (bus.if_instr !== HALT_INSN || bus.if_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_word: got instr=%0h valid=%0h expected b400001f/1", bus.if_instr, bus.if_valid); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("[TB] FAIL halted_set: got %0h expected 1", bus.halted); end
    checks++; if (bus.fetch_count !== 32'd3) begin errors++; $display("[TB] FAIL halt_count: got %0d expected 3", bus.fetch_count); end
    step();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_once: got %0h expected 0", bus.if_valid); end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'h154;
    step();
    step();
    bus.branch_taken = 1'b0;
    checks++; if (bus.if_valid !== 1'b0 || bus.halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_ignore: got valid=%0h halted=%0h expected 0/1", bus.if_valid, bus.halted); end
    checks++; if (bus.fetch_count !== 32'd3) begin errors++; $display("[TB] FAIL halt_count_frozen: got %0d expected 3", bus.fetch_count); end
    checks++; if (bus.imem_addr !== 7'd86) begin errors++; $display("[TB] FAIL halt_pc_hold: got %0d expected 86", bus.imem_addr); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("[TB] FAIL halt_fault: got %0h expected 0", bus.fault); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'ha0000000 + 32'(i);
    mem[0]  = 32'hf8000001;
    mem[85] = HALT_INSN;
    reset             = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;

    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_async_reset();
    test_fault();
    test_halt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the ARM64 pipeline processor. Owns the program counter, drives the word address of the combinational instruction memory, registers the fetched word into the IF/ID boundary, and applies stall, branch redirect, halt and fault handling. Sits between the instruction memory and the decode stage; redirects come from the MEM stage, where branches resolve.

## Interface
- N, 64, PC width
- IW, 32, instruction width
- AW, 7, instruction-memory word-address width (2^AW words)
- RESET_PC, 64'h0, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  AW  word address to imem, = pc[AW+1:2]
- imem_q  in  IW  instruction word from imem (combinational, same cycle)
- stall  in  1  hazard unit holds IF/ID
- branch_taken  in  1  MEM-stage redirect request
- branch_target  in  N  redirect byte address
- if_pc  out  N  PC of registered instruction
- if_instr  out  IW  registered instruction
- if_valid  out  1  if_instr/if_pc are live
- halted  out  1  halt instruction fetched; fetching stopped
- fault  out  1  misaligned redirect; fetching stopped
- fetch_count  out  32  count of instructions delivered with if_valid

## Operation
- States: BOOT, RUN, HALT, FAULT (enum in shared package).
- Reset (async, reset=0): state=BOOT, pc=RESET_PC, if_pc=0, if_instr=0, if_valid=0, halted=0, fault=0, fetch_count=0.
- BOOT: one cycle, no capture; next state RUN. Absorbs reset-release skew.
- RUN, per rising edge, priority high to low:
  - branch_taken: if branch_target[1:0]!=0 -> FAULT, if_valid<=0. Otherwise pc<=branch_target, if_valid<=0 (squash wrong-path fetch). Overrides stall and halt detection.
  - stall: pc, if_pc, if_instr, if_valid, fetch_count hold.
  - else: if_instr<=imem_q, if_pc<=pc, if_valid<=1, pc<=pc+4, fetch_count+=1. If imem_q==HALT_INSN, next state HALT.
- HALT: pc holds; if_valid<=0 on first non-stalled edge (halt word is delivered once); halted=1; branch_taken and stall ignored; exit only by reset.
- FAULT: if_valid=0, fault=1, pc holds; exit only by reset.
- Arithmetic: pc+4 wraps modulo 2^N; imem_addr ignores pc bits above AW+1, so fetch wraps at 4*2^AW bytes. fetch_count wraps at 2^32.
- Reset asserted mid-operation: all state returns to reset values immediately, no partial update.

## Timing
- imem_addr is combinational from pc register; no imem latency.
- First valid instruction: if_valid=1 after the second rising edge following reset deassertion (BOOT edge, then capture edge), with if_pc=RESET_PC.
- Steady state: one instruction per cycle; if_pc advances by 4 per non-stalled edge.
- Redirect: branch_taken sampled at edge k -> if_valid=0 after edge k; target instruction on if_* after edge k+1. One bubble.
- halted asserts the cycle after the edge that captured HALT_INSN; fault asserts the cycle after the faulting edge.
- stall and branch_taken high together: redirect taken, stall ignored.

## Structure
- Package fetch_pkg: state enum (BOOT, RUN, HALT, FAULT), HALT_INSN = 32'hb400001f (CBZ XZR, #0 self-loop), PC increment constant 4.
- No sub-module; pc, IF/ID registers, counter and FSM are inline. Instruction memory is instantiated by the parent; this block only drives its address.

## Test plan
- Reset/boot: hold reset low 3 cycles with imem word 0 = 32'hf8000001 -> all outputs 0 during reset; after release, if_valid rises after 2nd edge with if_pc=0, if_instr=32'hf8000001, fetch_count=1.
- Sequential: 5 unstalled cycles -> if_pc = 0,4,8,12,16, imem_addr = 0..4, fetch_count=5.
- Stall: assert stall 3 cycles at if_pc=8 -> if_pc/if_instr/fetch_count frozen, resumes at 12.
- Redirect with stall: branch_taken=1, stall=1, target=0x40 at one edge -> if_valid=0 next cycle, then if_pc=0x40, imem_addr=16; misaligned target 0x42 -> fault=1, if_valid=0 permanently until reset.
- Halt: word at 0x154 = 32'hb400001f -> delivered once with if_pc=0x154, then halted=1, if_valid=0; later branch_taken to 0x154 ignored; fetch_count frozen.
- Async reset mid-RUN: drop reset between edges at if_pc=0x20 -> outputs zero immediately; restart from RESET_PC.
